// File: rtl/csr_trap_unit_if.sv
// CSR / trap bus between the pipeline and csr_trap_unit.
// Strict valid/ready-free protocol: every request is single-cycle qualified by its own *_req level; redirect_valid is a one-cycle pulse.
interface csr_trap_unit_if;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        exc_req;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_req;
  logic        irq_meip;
  logic        irq_mtip;
  logic        irq_msip;
  logic [31:0] int_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  csr_req, csr_op, csr_addr, csr_wdata,
    input  exc_req, exc_code, exc_pc, exc_tval, mret_req,
    input  irq_meip, irq_mtip, irq_msip, int_pc,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );

  modport master (
    output csr_req, csr_op, csr_addr, csr_wdata,
    output exc_req, exc_code, exc_pc, exc_tval, mret_req,
    output irq_meip, irq_mtip, irq_msip, int_pc,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_unit.sv
// M-mode CSR file plus trap/MRET controller with a registered one-cycle fetch redirect.
module csr_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] VENDOR_ID   = 32'd0
) (
  input  logic            clk,
  input  logic            nrst,
  csr_trap_unit_if.slave  bus,
  output logic            o_dbg_state
);
  typedef enum logic {S_IDLE = 1'b0, S_REDIRECT = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_mstatus_mie, r_mstatus_mpie;
  logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_redirect_pc;

  logic [31:0] w_mstatus, w_mip, w_rdata, w_new, w_pend, w_base, w_int_target;
  logic        w_mapped, w_ro, w_illegal, w_int_pend;
  logic [3:0]  w_int_code;
  logic        w_take_exc, w_take_int, w_take_mret, w_csr_we;
  logic        w_unused;

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
  assign w_mip     = {20'b0, bus.irq_meip, 3'b0, bus.irq_mtip, 3'b0, bus.irq_msip, 3'b0};
  assign w_unused  = ^{bus.exc_pc[1:0], bus.int_pc[1:0]};

  always_comb begin
    w_rdata  = 32'd0;
    w_mapped = 1'b1;
    w_ro     = 1'b0;
    case (bus.csr_addr)
      12'h300: w_rdata = w_mstatus;
      12'h301: begin w_rdata = 32'h4000_0100; w_ro = 1'b1; end
      12'h304: w_rdata = r_mie;
      12'h305: w_rdata = r_mtvec;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mtval;
      12'h344: begin w_rdata = w_mip; w_ro = 1'b1; end
      12'hF11: begin w_rdata = VENDOR_ID; w_ro = 1'b1; end
      12'hF12: w_ro = 1'b1;
      12'hF13: w_ro = 1'b1;
      12'hF14: begin w_rdata = HART_ID; w_ro = 1'b1; end
      default: w_mapped = 1'b0;
    endcase
  end

  assign w_illegal = bus.csr_req & (~w_mapped | (w_ro & (bus.csr_op != 2'b00)));

  always_comb begin
    case (bus.csr_op)
      2'b01:   w_new = bus.csr_wdata;
      2'b10:   w_new = w_rdata | bus.csr_wdata;
      2'b11:   w_new = w_rdata & ~bus.csr_wdata;
      default: w_new = w_rdata;
    endcase
  end

  // Interrupt priority is MEI > MSI > MTI, not numeric order.
  assign w_pend     = w_mip & r_mie;
  assign w_int_pend = r_mstatus_mie & (|w_pend);
  always_comb begin
    if (w_pend[11])     w_int_code = 4'd11;
    else if (w_pend[3]) w_int_code = 4'd3;
    else                w_int_code = 4'd7;
  end
  assign w_base       = {r_mtvec[31:2], 2'b00};
  assign w_int_target = r_mtvec[0] ? (w_base + {26'b0, w_int_code, 2'b00}) : w_base;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take_exc  = 1'b0;
    w_take_int  = 1'b0;
    w_take_mret = 1'b0;
    w_csr_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.exc_req)       w_take_exc  = 1'b1;
        else if (w_int_pend)   w_take_int  = 1'b1;
        else if (bus.mret_req) w_take_mret = 1'b1;
        else if (bus.csr_req && bus.csr_op != 2'b00 && !w_illegal) w_csr_we = 1'b1;
        if (w_take_exc || w_take_int || w_take_mret) w_state_nxt = S_REDIRECT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'd0;
      r_mtvec        <= RESET_MTVEC & ~32'h2;
      r_mscratch     <= 32'd0;
      r_mepc         <= 32'd0;
      r_mcause       <= 32'd0;
      r_mtval        <= 32'd0;
      r_redirect_pc  <= 32'd0;
    end else if (w_take_exc) begin
      r_mepc         <= {bus.exc_pc[31:2], 2'b00};
      r_mcause       <= {28'b0, bus.exc_code};
      r_mtval        <= bus.exc_tval;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
      r_redirect_pc  <= w_base;
    end else if (w_take_int) begin
      r_mepc         <= {bus.int_pc[31:2], 2'b00};
      r_mcause       <= {1'b1, 27'b0, w_int_code};
      r_mtval        <= 32'd0;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
      r_redirect_pc  <= w_int_target;
    end else if (w_take_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
      r_redirect_pc  <= r_mepc;
    end else if (w_csr_we) begin
      case (bus.csr_addr)
        12'h300: begin r_mstatus_mie <= w_new[3]; r_mstatus_mpie <= w_new[7]; end
        12'h304: r_mie      <= w_new & 32'h0000_0888;
        12'h305: r_mtvec    <= {w_new[31:2], 1'b0, w_new[0]};
        12'h340: r_mscratch <= w_new;
        12'h341: r_mepc     <= {w_new[31:2], 2'b00};
        12'h342: r_mcause   <= w_new;
        12'h343: r_mtval    <= w_new;
        default: ;
      endcase
    end
  end

  assign bus.csr_rdata      = w_rdata;
  assign bus.csr_illegal    = w_illegal;
  assign bus.redirect_valid = (r_state == S_REDIRECT);
  assign bus.redirect_pc    = r_redirect_pc;
  assign o_dbg_state        = r_state;
endmodule
